counter_event_monitor: RTL and testbench

Downstream observer for the 32-bit up/down/load counter. It samples the counter's `data_out` every cycle and classifies each transition as wrap-up, wrap-down, load jump, or compare match. Events are queued in a small show-ahead FIFO with a valid/ready handshake, and saturating statistics counters are maintained. It adds no load on the counter path and sits between the counter and the status/interrupt logic.

---
 rtl/counter_mon_pkg.sv | 38 +++
 rtl/counter_event_monitor_if.sv | 28 ++
 rtl/evt_fifo.sv | 50 +++++
 rtl/counter_event_monitor.sv | 110 +++++++++++
 tb/tb_counter_event_monitor.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_mon_pkg.sv
// Shared types and helpers for the counter event monitor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package counter_mon_pkg;

    localparam int STAT_W    = 16;
    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        NONE      = 2'b00,
        WRAP_UP   = 2'b01,
        WRAP_DOWN = 2'b10,
        JUMP      = 2'b11
    } evt_kind_e;

    // Record layout at the default counter width; the FIFO carries the same
    // field order {kind, match, stamp} as a flat vector for any WIDTH.
    typedef struct packed {
        evt_kind_e              kind;
        logic                   match;
        logic [DEF_WIDTH-1:0]   stamp;
    } evt_rec_t;

    // Saturating statistics update. A clear wins over the old value, but an
    // event landing in the same cycle still counts as one.
    function automatic logic [STAT_W-1:0] stat_next(input logic [STAT_W-1:0] cnt,
                                                    input logic              hit,
                                                    input logic              clr);
        if (clr) begin
            return {{(STAT_W-1){1'b0}}, hit};
        end
        if (hit && (cnt != {STAT_W{1'b1}})) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/counter_event_monitor_if.sv
// Event stream handshake between the monitor (master) and its consumer (slave).
// Latency: n/a (wires only).
// Backpressure: consumer holds evt_ready low to keep the head entry in place.
interface counter_event_monitor_if #(
    parameter int WIDTH = 32
);
    logic             evt_valid;
    logic             evt_ready;
    logic [1:0]       evt_kind;
    logic             evt_match;
    logic [WIDTH-1:0] evt_stamp;

    modport master (
        output evt_valid,
        output evt_kind,
        output evt_match,
        output evt_stamp,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_kind,
        input  evt_match,
        input  evt_stamp,
        output evt_ready
    );
endinterface

// File: rtl/evt_fifo.sv
// Show-ahead FIFO; head data is valid whenever empty is low (zero when empty).
// Latency: a push is visible at the head on the following cycle.
// Backpressure: full refuses a push unless a pop happens in the same cycle.
// Ports: push/push_dat write side, pop/head_dat read side, full/empty status.
module evt_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // The extra MSB distinguishes full (wrapped once) from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot being written.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    // Storage is not reset, so the head is forced to zero while empty.
    assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/counter_event_monitor.sv
// Observes a counter's output, classifies each transition and queues event records.
// Latency: record and stats update on the edge ending the cycle the value appears.
// Backpressure: evt_ready low holds the queue; a push into a full queue is dropped
//   and flagged sticky on evt_lost (stats still count it).
// Ports: clk/rst_n, count_in, cmp_en/cmp_value, clr_stats, evt (event stream),
//   wrap_up_cnt/wrap_dn_cnt/jump_cnt saturating stats, evt_lost.
module counter_event_monitor
    import counter_mon_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  cmp_en,
    input  logic [WIDTH-1:0]      cmp_value,
    input  logic                  clr_stats,
    counter_event_monitor_if.master evt,
    output logic [STAT_W-1:0]     wrap_up_cnt,
    output logic [STAT_W-1:0]     wrap_dn_cnt,
    output logic [STAT_W-1:0]     jump_cnt,
    output logic                  evt_lost
);
    localparam int              REC_W = WIDTH + 3;
    localparam logic [WIDTH-1:0] MAXV = '1;

    logic [WIDTH-1:0] prev_q;
    logic             primed_q;
    evt_kind_e        kind;
    logic             cmp_hit;
    logic             push_req;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] push_dat;
    logic [REC_W-1:0] head_dat;

    // Sample register; the first edge after reset only loads prev_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            prev_q   <= count_in;
            primed_q <= 1'b1;
        end
    end

    // Wrap cases are tested before the +/-1 step check because MAX->0 and
    // 0->MAX are also single steps modulo 2^WIDTH.
    always_comb begin
        kind = NONE;
        if (prev_q == count_in) begin
            kind = NONE;
        end else if (prev_q == MAXV && count_in == '0) begin
            kind = WRAP_UP;
        end else if (prev_q == '0 && count_in == MAXV) begin
            kind = WRAP_DOWN;
        end else if (count_in == prev_q + WIDTH'(1) || count_in == prev_q - WIDTH'(1)) begin
            kind = NONE;
        end else begin
            kind = JUMP;
        end
    end

    // A held value never re-matches; only entering the match value counts.
    assign cmp_hit  = cmp_en && (count_in == cmp_value) && (prev_q != count_in);
    assign push_req = primed_q && ((kind != NONE) || cmp_hit);
    assign push_dat = {kind, cmp_hit, count_in};

    assign pop  = evt.evt_valid && evt.evt_ready;
    assign drop = push_req && fifo_full && !pop;

    evt_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_req),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_kind  = head_dat[REC_W-1 -: 2];
    assign evt.evt_match = head_dat[WIDTH];
    assign evt.evt_stamp = head_dat[WIDTH-1:0];

    // Statistics count every classified event, including dropped ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_up_cnt <= '0;
            wrap_dn_cnt <= '0;
            jump_cnt    <= '0;
            evt_lost    <= 1'b0;
        end else begin
            wrap_up_cnt <= stat_next(wrap_up_cnt, primed_q && kind == WRAP_UP,   clr_stats);
            wrap_dn_cnt <= stat_next(wrap_dn_cnt, primed_q && kind == WRAP_DOWN, clr_stats);
            jump_cnt    <= stat_next(jump_cnt,    primed_q && kind == JUMP,      clr_stats);
            evt_lost    <= drop | (evt_lost & ~clr_stats);
        end
    end

endmodule

// File: tb/tb_counter_event_monitor.sv
// Self-checking bench for counter_event_monitor: directed scenarios plus a
// randomized run checked against a queue-based reference model.
// Latency: n/a. Backpressure: bench drives evt_ready directly.
module tb_counter_event_monitor;
    import counter_mon_pkg::*;

    localparam logic [31:0] MAX32 = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] count_in = '0;
    logic        cmp_en = 1'b0;
    logic [31:0] cmp_value = '0;
    logic        clr_stats = 1'b0;
    logic [15:0] wrap_up_cnt, wrap_dn_cnt, jump_cnt;
    logic        evt_lost;

    int errors = 0;
    int checks = 0;

    counter_event_monitor_if #(.WIDTH(32)) ev ();

    counter_event_monitor #(.WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .count_in    (count_in),
        .cmp_en      (cmp_en),
        .cmp_value   (cmp_value),
        .clr_stats   (clr_stats),
        .evt         (ev.master),
        .wrap_up_cnt (wrap_up_cnt),
        .wrap_dn_cnt (wrap_dn_cnt),
        .jump_cnt    (jump_cnt),
        .evt_lost    (evt_lost)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_prev;
    bit          m_primed;
    evt_rec_t    m_q[$];
    int          m_up, m_dn, m_jp;
    bit          m_lost;

    function automatic void model_reset();
        m_prev = '0; m_primed = 0; m_q.delete();
        m_up = 0; m_dn = 0; m_jp = 0; m_lost = 0;
    endfunction

    function automatic void model_edge(input logic [31:0] c, input logic ce, input logic [31:0] cv,
                                       input logic clr, input logic rdy);
        evt_kind_e   k = NONE;
        bit          mt = 0;
        bit          pop = (m_q.size() > 0) && rdy;
        logic [31:0] d = c - m_prev;
        evt_rec_t    r;
        if (m_primed) begin
            if (d == 0)                             k = NONE;
            else if (m_prev == MAX32 && c == 0)     k = WRAP_UP;
            else if (m_prev == 0 && c == MAX32)     k = WRAP_DOWN;
            else if (d == 1 || d == MAX32)          k = NONE;
            else                                    k = JUMP;
            mt = ce && (c == cv) && (d != 0);
        end
        if (clr) begin m_up = 0; m_dn = 0; m_jp = 0; m_lost = 0; end
        if (k == WRAP_UP   && m_up < 65535) m_up++;
        if (k == WRAP_DOWN && m_dn < 65535) m_dn++;
        if (k == JUMP      && m_jp < 65535) m_jp++;
        if (pop) void'(m_q.pop_front());
        if (k != NONE || mt) begin
            r.kind = k; r.match = mt; r.stamp = c;
            if (m_q.size() < 4) m_q.push_back(r);
            else m_lost = 1;
        end
        m_prev = c; m_primed = 1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic [31:0] c, input logic ce, input logic [31:0] cv,
                         input logic clr, input logic rdy);
        count_in = c; cmp_en = ce; cmp_value = cv; clr_stats = clr; ev.evt_ready = rdy;
        @(posedge clk);
        model_edge(c, ce, cv, clr, rdy);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ev.evt_ready = 1'b0; clr_stats = 1'b0; cmp_en = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ev.evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ev.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", ev.evt_valid); end
        checks++; if (ev.evt_kind !== 2'b00) begin errors++; $display("FAIL reset_kind got=%0d exp=0", ev.evt_kind); end
        checks++; if (ev.evt_match !== 1'b0) begin errors++; $display("FAIL reset_match got=%0b exp=0", ev.evt_match); end
        checks++; if (ev.evt_stamp !== 32'h0) begin errors++; $display("FAIL reset_stamp got=%h exp=0", ev.evt_stamp); end
        checks++; if ({wrap_up_cnt, wrap_dn_cnt, jump_cnt} !== 48'h0) begin errors++; $display("FAIL reset_stats got=%h/%h/%h exp=0", wrap_up_cnt, wrap_dn_cnt, jump_cnt); end
        checks++; if (evt_lost !== 1'b0) begin errors++; $display("FAIL reset_lost got=%0b exp=0", evt_lost); end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_steps();
        do_reset();
        for (int i = 5; i <= 7; i++) begin
            cycle(32'(i), 1'b0, 32'h0, 1'b0, 1'b0);
            checks++; if (ev.evt_valid !== 1'b0) begin errors++; $display("FAIL step_valid value=%0d got=%0b exp=0", i, ev.evt_valid); end
        end
        checks++; if ({wrap_up_cnt, wrap_dn_cnt, jump_cnt} !== 48'h0) begin errors++; $display("FAIL step_stats got=%h/%h/%h exp=0", wrap_up_cnt, wrap_dn_cnt, jump_cnt); end
    endtask

    task automatic test_wraps();
        do_reset();
        cycle(MAX32, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if ({ev.evt_valid, ev.evt_kind, ev.evt_match, ev.evt_stamp} !== {1'b1, 2'b01, 1'b0, 32'h0})
            begin errors++; $display("FAIL wrap_up_rec got=%0b/%0d/%0b/%h exp=1/1/0/0", ev.evt_valid, ev.evt_kind, ev.evt_match, ev.evt_stamp); end
        cycle(MAX32, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (wrap_up_cnt !== 16'd1) begin errors++; $display("FAIL wrap_up_cnt got=%0d exp=1", wrap_up_cnt); end
        checks++; if (wrap_dn_cnt !== 16'd1) begin errors++; $display("FAIL wrap_dn_cnt got=%0d exp=1", wrap_dn_cnt); end
        cycle(MAX32, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if ({ev.evt_valid, ev.evt_kind, ev.evt_match, ev.evt_stamp} !== {1'b1, 2'b10, 1'b0, MAX32})
            begin errors++; $display("FAIL wrap_dn_rec got=%0b/%0d/%0b/%h exp=1/2/0/ffffffff", ev.evt_valid, ev.evt_kind, ev.evt_match, ev.evt_stamp); end
        cycle(MAX32, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (ev.evt_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained got=%0b exp=0", ev.evt_valid); end
    endtask

    task automatic test_match();
        do_reset();
        cycle(32'h0F, 1'b1, 32'h10, 1'b0, 1'b0);
        checks++; if (ev.evt_valid !== 1'b0) begin errors++; $display("FAIL match_early got=%0b exp=0", ev.evt_valid); end
        cycle(32'h10, 1'b1, 32'h10, 1'b0, 1'b0);
        checks++; if ({ev.evt_valid, ev.evt_kind, ev.evt_match, ev.evt_stamp} !== {1'b1, 2'b00, 1'b1, 32'h10})
            begin errors++; $display("FAIL match_rec got=%0b/%0d/%0b/%h exp=1/0/1/10", ev.evt_valid, ev.evt_kind, ev.evt_match, ev.evt_stamp); end
        cycle(32'h10, 1'b1, 32'h10, 1'b0, 1'b1);
        checks++; if (ev.evt_valid !== 1'b0) begin errors++; $display("FAIL match_held got=%0b exp=0", ev.evt_valid); end
        // jump straight onto a new compare value
        cycle(32'h1234, 1'b1, 32'h1234, 1'b0, 1'b0);
        checks++; if ({ev.evt_valid, ev.evt_kind, ev.evt_match, ev.evt_stamp} !== {1'b1, 2'b11, 1'b1, 32'h1234})
            begin errors++; $display("FAIL jump_match_rec got=%0b/%0d/%0b/%h exp=1/3/1/1234", ev.evt_valid, ev.evt_kind, ev.evt_match, ev.evt_stamp); end
        checks++; if (jump_cnt !== 16'd1) begin errors++; $display("FAIL jump_match_cnt got=%0d exp=1", jump_cnt); end
    endtask

    task automatic test_overflow();
        do_reset();
        cycle(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) cycle(32'(100 * i), 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (evt_lost !== 1'b1) begin errors++; $display("FAIL ovf_lost got=%0b exp=1", evt_lost); end
        checks++; if (jump_cnt !== 16'd5) begin errors++; $display("FAIL ovf_jump_cnt got=%0d exp=5", jump_cnt); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (ev.evt_valid !== 1'b1 || ev.evt_stamp !== 32'(100 * i))
                begin errors++; $display("FAIL ovf_drain_%0d got=%0b/%h exp=1/%h", i, ev.evt_valid, ev.evt_stamp, 32'(100 * i)); end
            cycle(32'd500, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        checks++; if (ev.evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%0b exp=0", ev.evt_valid); end
        cycle(32'd900, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (jump_cnt !== 16'd1) begin errors++; $display("FAIL clr_jump_cnt got=%0d exp=1", jump_cnt); end
        checks++; if (evt_lost !== 1'b0) begin errors++; $display("FAIL clr_lost got=%0b exp=0", evt_lost); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cycle(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) cycle(32'(10 * i), 1'b0, 32'h0, 1'b0, 1'b0);
        // full queue, push and pop together every cycle
        for (int i = 5; i <= 7; i++) begin
            cycle(32'(10 * i), 1'b0, 32'h0, 1'b0, 1'b1);
            checks++; if (ev.evt_stamp !== 32'(10 * (i - 3)) || evt_lost !== 1'b0)
                begin errors++; $display("FAIL b2b_%0d got=%h/%0b exp=%h/0", i, ev.evt_stamp, evt_lost, 32'(10 * (i - 3))); end
        end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        cycle(32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 65540; i++) cycle((i % 2 == 0) ? 32'h300 : 32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (jump_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_jump_cnt got=%h exp=ffff", jump_cnt); end
        for (int i = 1; i <= 3; i++) cycle(32'(i * 32'h1000), 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(32'h3000, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (ev.evt_valid !== 1'b1) begin errors++; $display("FAIL mid_drain_valid got=%0b exp=1", ev.evt_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if ({ev.evt_valid, ev.evt_kind, ev.evt_match, ev.evt_stamp} !== 36'h0)
            begin errors++; $display("FAIL async_rst_head got=%0b/%0d/%0b/%h exp=0", ev.evt_valid, ev.evt_kind, ev.evt_match, ev.evt_stamp); end
        checks++; if ({wrap_up_cnt, wrap_dn_cnt, jump_cnt, evt_lost} !== 49'h0)
            begin errors++; $display("FAIL async_rst_stats got=%h/%h/%h/%0b exp=0", wrap_up_cnt, wrap_dn_cnt, jump_cnt, evt_lost); end
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] c = 32'h0;
        logic [31:0] cv = 32'h10;
        logic        ce;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0:       c = c;
                1, 2:    c = c + 1;
                3:       c = c - 1;
                4:       c = MAX32;
                5:       c = 32'h0;
                6:       c = cv;
                7:       c = 32'($urandom_range(0, 20));
                default: c = $urandom;
            endcase
            if ($urandom_range(0, 19) == 0) cv = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : MAX32;
            ce = ($urandom_range(0, 3) != 0);
            cycle(c, ce, cv, ($urandom_range(0, 39) == 0), (((n / 16) % 2) == 0) ? 1'b1 : ($urandom_range(0, 3) == 0));
            checks++; if (ev.evt_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", n, ev.evt_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                checks++; if ({ev.evt_kind, ev.evt_match, ev.evt_stamp} !== m_q[0])
                    begin errors++; $display("FAIL rnd_head cyc=%0d got=%0d/%0b/%h exp=%0d/%0b/%h", n, ev.evt_kind, ev.evt_match, ev.evt_stamp, m_q[0].kind, m_q[0].match, m_q[0].stamp); end
            end
            checks++; if (wrap_up_cnt !== 16'(m_up) || wrap_dn_cnt !== 16'(m_dn) || jump_cnt !== 16'(m_jp) || evt_lost !== m_lost)
                begin errors++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d/%0d/%0b exp=%0d/%0d/%0d/%0b", n, wrap_up_cnt, wrap_dn_cnt, jump_cnt, evt_lost, m_up, m_dn, m_jp, m_lost); end
        end
    endtask

    initial begin
        ev.evt_ready = 1'b0;
        model_reset();
        test_reset();
        test_steps();
        test_wraps();
        test_match();
        test_overflow();
        test_back_to_back();
        test_saturate_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
